// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that shares one external WIDTH-bit D-flip-flop register among
// NREQ requesters, sequencing grant, load, read-back verify, bounded retry and ack.
module dff_reg_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                  c,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic                  busy,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  reg_we,
    input  logic [WIDTH-1:0]      reg_q,
    output logic [WIDTH-1:0]      rdata
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] reg_d_q, reg_d_d;
    logic             reg_we_q, reg_we_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [2:0]       retry_q, retry_d;
    logic [WIDTH-1:0] wbuf_q, wbuf_d;

    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    int               scan;

    // Walk from the far end back toward rr_q so the closest requester at/after rr_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = (int'(rr_q) + k) % NREQ;
            if (req[scan]) begin
                pick_valid = 1'b1;
                pick_idx   = PW'(scan);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = err_q;
        reg_d_d  = reg_d_q;
        reg_we_d = 1'b0;
        rdata_d  = rdata_q;
        rr_d     = rr_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        wbuf_d   = wbuf_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    idx_d    = pick_idx;
                    wbuf_d   = wdata[pick_idx*WIDTH +: WIDTH];
                    reg_d_d  = wdata[pick_idx*WIDTH +: WIDTH];
                    reg_we_d = 1'b1;
                    retry_d  = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: state_d = S_CHECK;
            S_CHECK: begin
                if (reg_q != wbuf_q && retry_q < 3'(MAX_RETRY)) begin
                    retry_d  = retry_q + 3'd1;
                    reg_d_d  = wbuf_q;
                    reg_we_d = 1'b1;
                    state_d  = S_LOAD;
                end else begin
                    err_d   = (reg_q != wbuf_q);
                    ack_d   = gnt_q;
                    rdata_d = reg_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                rr_d    = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            reg_d_q  <= '0;
            reg_we_q <= 1'b0;
            rdata_q  <= '0;
            rr_q     <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            reg_d_q  <= reg_d_d;
            reg_we_q <= reg_we_d;
            rdata_q  <= rdata_d;
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
        end
    end

    // The write buffer is pure data; it is always reloaded at grant before use.
    always_ff @(posedge c) begin
        wbuf_q <= wbuf_d;
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign reg_d  = reg_d_q;
    assign reg_we = reg_we_q;
    assign rdata  = rdata_q;
endmodule
